// File: rtl/note_run_encoder.sv
// Turns a captured per-eighth note array into merged (note, duration) tokens, split at bar lines.
// Optional RUN_TRIM_EN: trailing rests are dropped, and an all-rest array emits no tokens.
module note_run_encoder #(
  parameter int NUM_SLOTS = 160,
  parameter int NOTE_W    = 6,
  parameter int BAR_LEN   = 8,
  parameter int LEN_W     = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        start_in,
  input  logic [NUM_SLOTS*NOTE_W-1:0] notes_in,
  input  logic                        ready_in,
  output logic [NOTE_W-1:0]           note_out,
  output logic [LEN_W-1:0]            len_out,
  output logic                        valid_out,
  output logic                        busy_out,
  output logic                        done_out,
  output logic [7:0]                  token_count_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [NOTE_W-1:0] snap_q [NUM_SLOTS];
  logic [NOTE_W-1:0] run_note_q, run_note_d;
  logic [LEN_W-1:0]  run_len_q, run_len_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        end_q, end_d;
  logic [7:0]        count_q, count_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [LEN_W-1:0]  len_q, len_d;

  logic              capture;
  logic [7:0]        cap_end;
  logic [NOTE_W-1:0] cur_slot;
  logic              bar_edge;
  logic              at_end;

  assign capture = (state_q == S_IDLE) && start_in;

`ifdef RUN_TRIM_EN
  // Last non-rest slot wins; cap_end stays 0 for an all-rest array.
  always_comb begin
    cap_end = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (notes_in[i*NOTE_W +: NOTE_W] != '0) cap_end = 8'(i + 1);
    end
  end
`else
  always_comb begin
    cap_end = 8'(NUM_SLOTS);
  end
`endif

  always_comb begin
    cur_slot = '0;
    if (idx_q < 8'(NUM_SLOTS)) cur_slot = snap_q[idx_q];
  end

  assign bar_edge = (idx_q % 8'(BAR_LEN)) == 8'd0;
  assign at_end   = (idx_q == end_q);

  always_comb begin
    state_d    = state_q;
    run_note_d = run_note_q;
    run_len_d  = run_len_q;
    idx_d      = idx_q;
    end_d      = end_q;
    count_d    = count_q;
    note_d     = note_q;
    len_d      = len_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          run_note_d = notes_in[NOTE_W-1:0];
          run_len_d  = LEN_W'(1);
          idx_d      = 8'd1;
          count_d    = '0;
          end_d      = cap_end;
          state_d    = (cap_end == 8'd0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (at_end || (cur_slot != run_note_q) || bar_edge) begin
          note_d  = run_note_q;
          len_d   = run_len_q;
          state_d = S_EMIT;
        end else begin
          run_len_d = run_len_q + LEN_W'(1);
          idx_d     = idx_q + 8'd1;
        end
      end
      S_EMIT: begin
        if (ready_in) begin
          count_d = count_q + 8'd1;
          if (at_end) begin
            state_d = S_DONE;
          end else begin
            run_note_d = cur_slot;
            run_len_d  = LEN_W'(1);
            idx_d      = idx_q + 8'd1;
            state_d    = S_SCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      run_note_q <= '0;
      run_len_q  <= '0;
      idx_q      <= '0;
      end_q      <= '0;
      count_q    <= '0;
      note_q     <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_note_q <= run_note_d;
      run_len_q  <= run_len_d;
      idx_q      <= idx_d;
      end_q      <= end_d;
      count_q    <= count_d;
      note_q     <= note_d;
      len_q      <= len_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) snap_q[i] <= '0;
    end else if (capture) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) snap_q[i] <= notes_in[i*NOTE_W +: NOTE_W];
    end
  end

  assign note_out        = note_q;
  assign len_out         = len_q;
  assign valid_out       = (state_q == S_EMIT);
  assign busy_out        = (state_q != S_IDLE);
  assign done_out        = (state_q == S_DONE);
  assign token_count_out = count_q;

endmodule

// File: tb/tb_note_run_encoder.sv
// Bench for note_run_encoder: segment-based token model plus a per-cycle output monitor.
module tb_note_run_encoder;
  localparam int NS = 160;
  localparam int NW = 6;
  localparam int BL = 8;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [NS*NW-1:0]  notes;
  logic              ready;
  logic [NW-1:0]     note_out;
  logic [LW-1:0]     len_out;
  logic              valid_out, busy_out, done_out;
  logic [7:0]        token_count_out;

  note_run_encoder #(.NUM_SLOTS(NS), .NOTE_W(NW), .BAR_LEN(BL), .LEN_W(LW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .notes_in(notes), .ready_in(ready),
    .note_out(note_out), .len_out(len_out), .valid_out(valid_out), .busy_out(busy_out),
    .done_out(done_out), .token_count_out(token_count_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: cut the captured slots into segments of equal notes, restarting at bar lines.
  int exp_note[$];
  int exp_len[$];
  int exp_end;

  function automatic void build_model(input logic [NS*NW-1:0] arr);
    int slot[NS];
    exp_note.delete();
    exp_len.delete();
    for (int i = 0; i < NS; i++) slot[i] = int'(arr[i*NW +: NW]);
    exp_end = NS;
`ifdef RUN_TRIM_EN
    exp_end = 0;
    for (int i = 0; i < NS; i++) if (slot[i] != 0) exp_end = i + 1;
`endif
    for (int i = 0; i < exp_end; i++) begin
      if (i == 0) begin
        exp_note.push_back(slot[i]); exp_len.push_back(1);
      end else if ((i % BL) == 0 || slot[i] != slot[i-1]) begin
        exp_note.push_back(slot[i]); exp_len.push_back(1);
      end else begin
        exp_len[exp_len.size()-1] = exp_len[exp_len.size()-1] + 1;
      end
    end
  endfunction

  // Monitor: sampled on the falling edge, checks every presented token and the done pulse.
  logic mon_en;
  int   ptr;
  int   done_seen;
  logic pv, pr, pdone;
  int   pn, pl;

  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      pv = 1'b0; pr = 1'b0; pdone = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("valid_held", valid_out, 1);
        chk("hold_note", note_out, pn);
        chk("hold_len", len_out, pl);
      end
      if (valid_out) begin
        chk("token_in_range", ptr < exp_note.size(), 1);
        if (ptr < exp_note.size()) begin
          chk("tok_note", note_out, exp_note[ptr]);
          chk("tok_len", len_out, exp_len[ptr]);
        end
        if (ready) ptr++;
      end
      if (pdone) chk("done_one_cycle", done_out, 0);
      if (done_out) begin
        done_seen++;
        chk("done_ptr", ptr, exp_note.size());
        chk("done_count", token_count_out, exp_note.size());
      end
      pv = valid_out; pr = ready; pn = int'(note_out); pl = int'(len_out); pdone = done_out;
    end
  end

  int first_note, first_len;

  task automatic run_pass(input string tag, input logic [NS*NW-1:0] arr, input int stall_first,
                          input logic disturb, input logic [NS*NW-1:0] alt);
    int cyc;
    int st;
    logic seen;
    @(posedge clk); #1;
    build_model(arr);
    ptr = 0; done_seen = 0; st = 0; seen = 1'b0;
    notes = arr; start = 1'b1; ready = (stall_first == 0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done_out && cyc < 2000) begin
      if (valid_out && !seen) begin
        seen = 1'b1; first_note = int'(note_out); first_len = int'(len_out);
      end
      if (!ready && valid_out) begin
        if (st == stall_first) ready = 1'b1;
        else st++;
      end
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc == 3) begin notes = alt; start = 1'b1; end
      if (disturb && cyc == 4) start = 1'b0;
    end
    chk({tag, "_done_reached"}, done_out, 1);
    if (stall_first == 0) chk({tag, "_cycles"}, cyc, exp_end + exp_note.size());
    @(posedge clk); #1;
    chk({tag, "_done_pulses"}, done_seen, 1);
    chk({tag, "_idle_busy"}, busy_out, 0);
    chk({tag, "_count_held"}, token_count_out, exp_note.size());
    ready = 1'b0;
  endtask

  logic [NS*NW-1:0] zero_arr, t2_arr, alt_arr, rnd_arr;

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; notes = '0; mon_en = 1'b1;
    ptr = 0; done_seen = 0;
    zero_arr = '0;
    t2_arr = '0;
    for (int i = 0; i < 3; i++) t2_arr[i*NW +: NW] = 6'd12;
    for (int i = 3; i < 11; i++) t2_arr[i*NW +: NW] = 6'd20;
    for (int i = 0; i < NS; i++) alt_arr[i*NW +: NW] = (i % 2 == 0) ? 6'd5 : 6'd6;
    for (int i = 0; i < NS; i++) rnd_arr[i*NW +: NW] = 6'($urandom_range(1, 3));

    #12;
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_count", token_count_out, 0);
    chk("rst_note", note_out, 0);
    #11 rst_n = 1'b1;

    // Model pinned against hand-derived token lists.
    build_model(zero_arr);
`ifdef RUN_TRIM_EN
    chk("model_zero_n", exp_note.size(), 0);
`else
    chk("model_zero_n", exp_note.size(), 20);
    chk("model_zero_len", exp_len[19], 8);
`endif
    build_model(t2_arr);
`ifdef RUN_TRIM_EN
    chk("model_t2_n", exp_note.size(), 3);
`else
    chk("model_t2_n", exp_note.size(), 22);
    chk("model_t2_tok3", exp_len[3], 5);
    chk("model_t2_tok4", exp_len[4], 8);
`endif
    chk("model_t2_n0", exp_note[0], 12);
    chk("model_t2_l0", exp_len[0], 3);
    chk("model_t2_n1", exp_note[1], 20);
    chk("model_t2_l1", exp_len[1], 5);
    chk("model_t2_l2", exp_len[2], 3);
    build_model(alt_arr);
    chk("model_alt_n", exp_note.size(), 160);

    run_pass("zero", zero_arr, 0, 1'b0, '0);
`ifdef RUN_TRIM_EN
    chk("zero_count_lit", token_count_out, 0);
`else
    chk("zero_count_lit", token_count_out, 20);
`endif

    run_pass("t2", t2_arr, 0, 1'b0, '0);
`ifdef RUN_TRIM_EN
    chk("t2_count_lit", token_count_out, 3);
`else
    chk("t2_count_lit", token_count_out, 22);
`endif

    run_pass("bp", t2_arr, 5, 1'b0, '0);
    chk("bp_first_note", first_note, 12);
    chk("bp_first_len", first_len, 3);

    run_pass("alt", alt_arr, 0, 1'b0, '0);
    chk("alt_count_lit", token_count_out, 160);

    run_pass("snap", rnd_arr, 0, 1'b1, alt_arr);

    // Reset while a token is pending: outputs must drop between clock edges.
    @(posedge clk); #1;
    build_model(t2_arr);
    ptr = 0;
    notes = t2_arr; start = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && !valid_out; c++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_valid_before", valid_out, 1);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", valid_out, 0);
    chk("rst_mid_busy", busy_out, 0);
    chk("rst_mid_done", done_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_pass("after_rst", t2_arr, 0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
